// File: rtl/actividad_03.sv
// actividad_03: registered logic-gate evaluator.
// Applies AND, OR, XOR, NOT, NAND, YES, NOR and XNOR bitwise to two operands
// and presents each result on its own port one clock after sampling.
module actividad_03 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] entrada1,
    input  logic [WIDTH-1:0] entrada2,
    output logic [WIDTH-1:0] salidaand,
    output logic [WIDTH-1:0] salidaor,
    output logic [WIDTH-1:0] salidaxor,
    output logic [WIDTH-1:0] salidanot,
    output logic [WIDTH-1:0] salidanand,
    output logic [WIDTH-1:0] salidayes,
    output logic [WIDTH-1:0] salidanor,
    output logic [WIDTH-1:0] salidaxnor,
    output logic             valido
);

    logic [WIDTH-1:0] salidaAnd_d,  salidaAnd_q;
    logic [WIDTH-1:0] salidaOr_d,   salidaOr_q;
    logic [WIDTH-1:0] salidaXor_d,  salidaXor_q;
    logic [WIDTH-1:0] salidaNot_d,  salidaNot_q;
    logic [WIDTH-1:0] salidaNand_d, salidaNand_q;
    logic [WIDTH-1:0] salidaYes_d,  salidaYes_q;
    logic [WIDTH-1:0] salidaNor_d,  salidaNor_q;
    logic [WIDTH-1:0] salidaXnor_d, salidaXnor_q;
    logic             valido_d,     valido_q;

    // Next-state: every gate function of the current operands, bit by bit.
    always_comb begin
        salidaAnd_d  = entrada1 & entrada2;
        salidaOr_d   = entrada1 | entrada2;
        salidaXor_d  = entrada1 ^ entrada2;
        salidaNot_d  = ~entrada1;
        salidaNand_d = ~(entrada1 & entrada2);
        salidaYes_d  = entrada1;
        salidaNor_d  = ~(entrada1 | entrada2);
        salidaXnor_d = ~(entrada1 ^ entrada2);
        valido_d     = 1'b1;
    end

    // Result registers: reset clears everything (including the inverting gates), otherwise load every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            salidaAnd_q  <= '0;
            salidaOr_q   <= '0;
            salidaXor_q  <= '0;
            salidaNot_q  <= '0;
            salidaNand_q <= '0;
            salidaYes_q  <= '0;
            salidaNor_q  <= '0;
            salidaXnor_q <= '0;
            valido_q     <= 1'b0;
        end else begin
            salidaAnd_q  <= salidaAnd_d;
            salidaOr_q   <= salidaOr_d;
            salidaXor_q  <= salidaXor_d;
            salidaNot_q  <= salidaNot_d;
            salidaNand_q <= salidaNand_d;
            salidaYes_q  <= salidaYes_d;
            salidaNor_q  <= salidaNor_d;
            salidaXnor_q <= salidaXnor_d;
            valido_q     <= valido_d;
        end
    end

    assign salidaand  = salidaAnd_q;
    assign salidaor   = salidaOr_q;
    assign salidaxor  = salidaXor_q;
    assign salidanot  = salidaNot_q;
    assign salidanand = salidaNand_q;
    assign salidayes  = salidaYes_q;
    assign salidanor  = salidaNor_q;
    assign salidaxnor = salidaXnor_q;
    assign valido     = valido_q;

endmodule

// File: tb/tb_actividad_03.sv
// Testbench for actividad_03: a 1-bit and an 8-bit instance share clock and
// reset; expected results come from per-function truth tables and travel
// through a scoreboard queue to be compared one cycle after being driven.
module tb_actividad_03;

    logic       clk;
    logic       rst;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       and1, or1, xor1, not1, nand1, yes1, nor1, xnor1, valid1;
    logic [7:0] and8, or8, xor8, not8, nand8, yes8, nor8, xnor8;
    logic       valid8;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct packed {
        logic [7:0][7:0] res8;
        logic [7:0]      res1;
        logic            valid;
    } expect_t;

    expect_t sbQueue[$];

    actividad_03 #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .entrada1(a1), .entrada2(b1),
        .salidaand(and1), .salidaor(or1), .salidaxor(xor1), .salidanot(not1),
        .salidanand(nand1), .salidayes(yes1), .salidanor(nor1), .salidaxnor(xnor1),
        .valido(valid1)
    );

    actividad_03 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .entrada1(a8), .entrada2(b8),
        .salidaand(and8), .salidaor(or8), .salidaxor(xor8), .salidanot(not8),
        .salidanand(nand8), .salidayes(yes8), .salidanor(nor8), .salidaxnor(xnor8),
        .valido(valid8)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Truth table per function, indexed by {a,b}: 0=and 1=or 2=xor 3=not 4=nand 5=yes 6=nor 7=xnor.
    function automatic logic modelBit(input int fn, input logic a, input logic b);
        logic [3:0] tt;
        logic [1:0] idx;
        case (fn)
            0: tt = 4'b1000;
            1: tt = 4'b1110;
            2: tt = 4'b0110;
            3: tt = 4'b0011;
            4: tt = 4'b0111;
            5: tt = 4'b1100;
            6: tt = 4'b0001;
            7: tt = 4'b1001;
            default: tt = 4'b0000;
        endcase
        idx = {a, b};
        return tt[idx];
    endfunction

    function automatic expect_t buildExpect(input logic rstIn, input logic a1In, input logic b1In,
                                            input logic [7:0] a8In, input logic [7:0] b8In);
        expect_t e;
        e = '0;
        if (!rstIn) begin
            e.valid = 1'b1;
            for (int fn = 0; fn < 8; fn++) begin
                e.res1[fn] = modelBit(fn, a1In, b1In);
                for (int bitPos = 0; bitPos < 8; bitPos++)
                    e.res8[fn][bitPos] = modelBit(fn, a8In[bitPos], b8In[bitPos]);
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h at time %0t", tag, observed, expected, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge and records what the next rising edge must produce.
    // With glitch set, the inputs first take inverted values that must not reach the outputs.
    task automatic applyStimulus(input logic rstIn, input logic a1In, input logic b1In,
                                 input logic [7:0] a8In, input logic [7:0] b8In, input bit glitch);
        @(negedge clk);
        rst = rstIn;
        if (glitch) begin
            a1 = ~a1In; b1 = ~b1In; a8 = ~a8In; b8 = ~b8In;
            #2;
        end
        a1 = a1In; b1 = b1In; a8 = a8In; b8 = b8In;
        sbQueue.push_back(buildExpect(rstIn, a1In, b1In, a8In, b8In));
    endtask

    // Monitor: just after each rising edge, pop one expectation and compare both instances.
    initial begin
        expect_t exp;
        logic [7:0] obs1;
        logic [7:0][7:0] obs8;
        string names[8];
        names = '{"and", "or", "xor", "not", "nand", "yes", "nor", "xnor"};
        forever begin
            @(posedge clk);
            #1;
            if (sbQueue.size() > 0) begin
                exp  = sbQueue.pop_front();
                obs1 = {xnor1, nor1, yes1, nand1, not1, xor1, or1, and1};
                obs8 = {xnor8, nor8, yes8, nand8, not8, xor8, or8, and8};
                for (int fn = 0; fn < 8; fn++) begin
                    checkOutput({"w1_", names[fn]}, {7'b0, obs1[fn]}, {7'b0, exp.res1[fn]});
                    checkOutput({"w8_", names[fn]}, obs8[fn], exp.res8[fn]);
                end
                checkOutput("w1_valido", {7'b0, valid1}, {7'b0, exp.valid});
                checkOutput("w8_valido", {7'b0, valid8}, {7'b0, exp.valid});
            end
        end
    end

    initial begin
        rst = 1'b1; a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;

        // Reset held for two edges with ones on the operands.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);

        // Directed vectors; the 8-bit instance carries the A5/0F case and its neighbours.
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hA5, 8'h0F, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h5A, 8'hF0, 1'b0);

        // Mid-run reset while inputs keep changing, then resume.
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h3C, 8'hC3, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h81, 8'h18, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'hA5, 8'h0F, 1'b0);

        // Inputs that change between edges: only the value present at the edge counts.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h96, 8'h69, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h0F, 8'hA5, 1'b1);

        // Random traffic with an occasional reset.
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra, rb;
            logic rr;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rr = ($urandom_range(0, 9) == 0);
            applyStimulus(rr, ra[0], rb[0], ra, rb, bit'($urandom_range(0, 1)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int waitCycles = 0; waitCycles < 5 && sbQueue.size() > 0; waitCycles++)
            @(posedge clk);
        #3;
        if (sbQueue.size() > 0) begin
            errorCount++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", sbQueue.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/actividad_03.md
Name: actividad_03

Overview:
- Registered logic-gate evaluator: applies eight basic Boolean functions (AND, OR, XOR, NOT, NAND, YES/buffer, NOR, XNOR) bitwise to two input operands.
- Each result is presented on its own output port.
- Used as a small combinational-function block with a registered boundary, so downstream logic sees stable, clock-aligned results.
- One clock domain; synchronous active-high reset.

Parameters:
- WIDTH, 1, bit width of both operands and of every result output (WIDTH >= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- entrada1  input  WIDTH  operand A
- entrada2  input  WIDTH  operand B
- salidaand  output  WIDTH  registered A & B
- salidaor  output  WIDTH  registered A | B
- salidaxor  output  WIDTH  registered A ^ B
- salidanot  output  WIDTH  registered ~A (operand B unused)
- salidanand  output  WIDTH  registered ~(A & B)
- salidayes  output  WIDTH  registered A (buffer; operand B unused)
- salidanor  output  WIDTH  registered ~(A | B)
- salidaxnor  output  WIDTH  registered ~(A ^ B)
- valido  output  1  high when the result registers hold a computed (post-reset) value

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst), sampled only on the rising edge of clk.
- Reset values: when rst=1 at a rising edge, all eight result outputs go to all-zeros and valido goes to 0. This applies even for NOT/NAND/NOR/XNOR, whose functional value for zero inputs would be ones.
- Normal operation (rst=0): on every rising edge, each output register loads its function of the current entrada1/entrada2, evaluated bitwise per bit position. Bit i of each result depends only on bit i of the operands.
- valido is set to 1 on the first non-reset edge and stays 1 until the next reset.
- Latency: exactly 1 clock. Inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
- No enable and no handshake: a new value is computed on every cycle.
- Inputs changing between edges have no effect on the outputs until the next edge. The outputs are glitch-free.
- Reset mid-operation: reset has priority over computation on the same edge. Outputs clear on that edge; computation resumes on the first edge with rst=0.
- Width rules: no carries and no cross-bit interaction; all outputs are exactly WIDTH bits.
- X/Z on the inputs is not handled specially and propagates per standard operator semantics.
- Identities that must hold whenever valido=1:
  - salidanand = ~salidaand
  - salidanor = ~salidaor
  - salidaxnor = ~salidaxor
  - salidanot = ~salidayes

Test Plan:
- Reset: hold rst=1 for 2 edges with entrada1=1, entrada2=1 -> all outputs 0, valido=0.
- Vector (A=0, B=1), WIDTH=1: after one edge -> and=0, or=1, xor=1, not=1, nand=1, yes=0, nor=0, xnor=0, valido=1.
- Vector (A=1, B=1): after one edge -> and=1, or=1, xor=0, not=0, nand=0, yes=1, nor=0, xnor=1.
- Exhaustive 1-bit: drive 00, 01, 10, 11 on consecutive cycles -> each output matches its truth table exactly 1 cycle later. For 00: not=1, nand=1, nor=1, xnor=1, all others 0.
- Mid-run reset: apply (A=1, B=0), then assert rst for one edge while inputs keep changing -> outputs 0 and valido=0 on that edge; the next edge with rst=0 shows results for the inputs present at that edge.
- WIDTH=8: A=8'hA5, B=8'h0F -> and=05, or=AF, xor=AA, not=5A, nand=FA, yes=A5, nor=50, xnor=55.
